// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between a processor-side master and mem_responder
//   req_valid/req_we/req_addr/req_wdata : request from master
//   req_ready                           : responder can accept this cycle
//   rsp_valid/rsp_we/rsp_rdata          : single-cycle response, read data held until next read
//   busy                                : request in flight
interface mem_responder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_we;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata, busy
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_we, rsp_rdata, busy
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory responder with a side-band preload port
//   clk, reset (async, active-low)
//   bus       : mem_responder_if slave (request/response handshake)
//   load_en/load_addr/load_data : preload write, honoured only while idle
//   load_err  : one-cycle pulse when a preload was dropped because a request was in flight
module mem_responder #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_responder_if.slave    bus,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_err
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    localparam logic [2:0] CNT_INIT = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);
    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              load_err_q, load_err_d;
    logic              accept, enter_resp, mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    assign bus.req_ready = (state_q == S_IDLE) & ~load_en & reset;
    assign bus.busy      = state_q != S_IDLE;
    assign bus.rsp_valid = state_q == S_RESP;
    assign bus.rsp_we    = (state_q == S_RESP) & we_q;
    assign bus.rsp_rdata = rdata_q;
    assign load_err      = load_err_q;
    assign accept        = bus.req_valid & bus.req_ready;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        load_err_d = load_en & (state_q != S_IDLE);
        case (state_q)
            S_IDLE: if (accept) begin
                addr_d  = bus.req_addr;
                we_d    = bus.req_we;
                wdata_d = bus.req_wdata;
                cnt_d   = CNT_INIT;
                state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                cnt_d   = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
                state_d = (cnt_q == 3'd0) ? S_RESP : S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
        // The access happens on the edge that enters RESP; with zero wait states that is
        // the accept edge itself, so the *_d values (fresh from the bus) are used.
        enter_resp = state_d == S_RESP && state_q != S_RESP;
        rdata_d    = (enter_resp & ~we_d) ? mem[addr_d] : rdata_q;
        mem_we     = reset & ((enter_resp & we_d) | (load_en & (state_q == S_IDLE)));
        mem_waddr  = enter_resp ? addr_d : load_addr;
        mem_wdata  = enter_resp ? wdata_d : load_data;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            load_err_q <= load_err_d;
        end
    end
    // Storage is deliberately not reset so preloaded contents survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end
endmodule
